ram1_arbiter: RTL and testbench

RAM1_ARBITER -- requirements
Module: ram1_arbiter

---
 rtl/ram1_arbiter_if.sv | 25 ++
 rtl/ram1_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram1_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram1_arbiter_if.sv
// Requester-side bundle of the RAM1 arbiter: fetch (read-only) port and data port.
// Modport master belongs to the requesters, modport slave to the arbiter.
interface ram1_arbiter_if;
  logic        if_req;
  logic [17:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;

  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
    output if_rdata, if_ack, mem_rdata, mem_ack
  );
endinterface

// File: rtl/ram1_arbiter.sv
// Two-port arbiter onto one async SRAM (fetch read port + data r/w port); RAM1_ARB_RR_EN selects round-robin ties.
// Latency: request sampled at end of cycle T -> ack pulse in cycle T+2+WAIT_CYCLES.
// Backpressure: requests are only sampled in IDLE; a held req simply waits, a dropped req after grant still completes.
module ram1_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  ram1_arbiter_if.slave arb,
  output logic [17:0] Ram1Addr,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  inout  wire  [15:0] Ram1Data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_e;

  localparam logic [1:0] LAST_CNT = 2'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        grant_mem_q, grant_mem_d;
  logic [17:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic        any_req;
  logic        pick_mem;
  logic        drive_dat;

`ifdef RAM1_ARB_RR_EN
  // Reset value 0 means "fetch was granted last", so the first tie goes to mem.
  logic last_mem_q, last_mem_d;

  always_comb begin
    pick_mem = arb.mem_req && (!arb.if_req || !last_mem_q);
  end
`else
  always_comb begin
    pick_mem = arb.mem_req;
  end
`endif

  assign any_req = arb.if_req || arb.mem_req;

  always_comb begin
    state_d     = state_q;
    grant_mem_d = grant_mem_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef RAM1_ARB_RR_EN
    last_mem_d  = last_mem_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_mem_d = pick_mem;
          // The fetch port is read-only whatever mem_we happens to be.
          addr_d      = pick_mem ? arb.mem_addr : arb.if_addr;
          we_d        = pick_mem && arb.mem_we;
          wdata_d     = pick_mem ? arb.mem_wdata : wdata_q;
          cnt_d       = 2'd0;
          state_d     = ST_SETUP;
`ifdef RAM1_ARB_RR_EN
          last_mem_d  = pick_mem;
`endif
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (grant_mem_q) begin
              mem_rdata_d = Ram1Data;
            end else begin
              if_rdata_d = Ram1Data;
            end
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_mem_q <= 1'b0;
      addr_q      <= 18'd0;
      we_q        <= 1'b0;
      wdata_q     <= 16'd0;
      cnt_q       <= 2'd0;
      if_rdata_q  <= 16'd0;
      mem_rdata_q <= 16'd0;
`ifdef RAM1_ARB_RR_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_mem_q <= grant_mem_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef RAM1_ARB_RR_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  // Pins decode from registered state only, so reset releases them asynchronously.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    Ram1Addr  = addr_q;
    Ram1EN    = !busy;
    Ram1OE    = !((state_q == ST_ACCESS) && !we_q);
    Ram1WE    = !((state_q == ST_ACCESS) && we_q);
    drive_dat = busy && we_q;
  end

  assign Ram1Data = drive_dat ? wdata_q : 16'hzzzz;

  assign arb.if_ack    = (state_q == ST_DONE) && !grant_mem_q;
  assign arb.mem_ack   = (state_q == ST_DONE) && grant_mem_q;
  assign arb.if_rdata  = if_rdata_q;
  assign arb.mem_rdata = mem_rdata_q;

  a_one_ack : assert property (@(posedge clk) disable iff (!rst)
    !(arb.if_ack && arb.mem_ack));

  a_ack_in_done : assert property (@(posedge clk) disable iff (!rst)
    (arb.if_ack || arb.mem_ack) |-> (state_q == ST_DONE));

endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, each on a small SRAM model.
module tb_ram1_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        if_req, mem_req, mem_we, sel3;
  logic [17:0] if_addr, mem_addr;
  logic [15:0] mem_wdata;

  ram1_arbiter_if bus1 ();
  ram1_arbiter_if bus3 ();

  assign bus1.if_req    = if_req;
  assign bus1.if_addr   = if_addr;
  assign bus1.mem_req   = mem_req;
  assign bus1.mem_we    = mem_we;
  assign bus1.mem_addr  = mem_addr;
  assign bus1.mem_wdata = mem_wdata;
  assign bus3.if_req    = if_req;
  assign bus3.if_addr   = if_addr;
  assign bus3.mem_req   = mem_req;
  assign bus3.mem_we    = mem_we;
  assign bus3.mem_addr  = mem_addr;
  assign bus3.mem_wdata = mem_wdata;

  wire  [15:0] d1, d3;
  logic [17:0] a1, a3;
  logic        oe1, we1, en1, busy1, oe3, we3, en3, busy3;

  ram1_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .arb(bus1), .Ram1Addr(a1), .Ram1OE(oe1),
    .Ram1WE(we1), .Ram1EN(en1), .Ram1Data(d1), .busy(busy1)
  );

  ram1_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .arb(bus3), .Ram1Addr(a3), .Ram1OE(oe3),
    .Ram1WE(we3), .Ram1EN(en3), .Ram1Data(d3), .busy(busy3)
  );

  // An undriven data bus reads back as all ones.
  pullup pu1 (d1);
  pullup pu3 (d3);

  logic [15:0] sram1 [32];
  logic [15:0] sram3 [32];

  assign d1 = (!en1 && !oe1) ? sram1[a1[4:0]] : 16'hzzzz;
  assign d3 = (!en3 && !oe3) ? sram3[a3[4:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) sram1[i] <= 16'hC000 | 16'(i);
      sram1[1] <= 16'h0004;
    end else if (!en1 && !we1) begin
      sram1[a1[4:0]] <= d1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) sram3[i] <= 16'hC000 | 16'(i);
      sram3[2] <= 16'h1234;
    end else if (!en3 && !we3) begin
      sram3[a3[4:0]] <= d3;
    end
  end

  logic        o_oe, o_we, o_busy, o_ifack, o_memack;
  logic [15:0] o_dat, o_ifrd, o_memrd;
  assign o_oe     = sel3 ? oe3 : oe1;
  assign o_we     = sel3 ? we3 : we1;
  assign o_busy   = sel3 ? busy3 : busy1;
  assign o_ifack  = sel3 ? bus3.if_ack : bus1.if_ack;
  assign o_memack = sel3 ? bus3.mem_ack : bus1.mem_ack;
  assign o_dat    = sel3 ? d3 : d1;
  assign o_ifrd   = sel3 ? bus3.if_rdata : bus1.if_rdata;
  assign o_memrd  = sel3 ? bus3.mem_rdata : bus1.mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One-cycle request pulse; counts strobe/drive cycles from SETUP up to and including the ack cycle.
  task automatic run_txn(input logic is_mem, input logic wr, input logic [17:0] a,
                         input logic [15:0] wd, output int lat, output int oe_lo,
                         output int we_lo, output int drv, output int wrong_ack);
    @(negedge clk);
    if (is_mem) begin
      mem_req  = 1'b1;
      mem_addr = a;
    end else begin
      if_req  = 1'b1;
      if_addr = a;
    end
    mem_we    = wr;
    mem_wdata = wd;
    lat = -1; oe_lo = 0; we_lo = 0; drv = 0; wrong_ack = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if_req  = 1'b0;
      mem_req = 1'b0;
      if (!o_oe) oe_lo++;
      if (!o_we) we_lo++;
      if (o_dat == wd) drv++;
      if (is_mem ? o_ifack : o_memack) wrong_ack++;
      if (is_mem ? o_memack : o_ifack) begin
        lat = c;
        break;
      end
    end
    @(negedge clk);
    chk("bus_released", 32'(o_dat), 32'hFFFF);
    chk("idle_after", 32'(o_busy), 32'd0);
  endtask

  int lat, oe_lo, we_lo, drv, wrong;
  int n_acks, n_mem, n_if, alt_err, both_ack, prev_mem;
  int ack_cyc [2];
  int ack_mem [2];

  initial begin
    rst = 1'b0; sel3 = 1'b0;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_en", 32'(en1), 32'd1);
    chk("rst_oe", 32'(oe1), 32'd1);
    chk("rst_we", 32'(we1), 32'd1);
    chk("rst_addr", 32'(a1), 32'd0);
    chk("rst_data_z", 32'(d1), 32'hFFFF);
    chk("rst_acks", {30'd0, bus1.if_ack, bus1.mem_ack}, 32'd0);
    chk("rst_rdata", {bus1.if_rdata, bus1.mem_rdata}, 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch of word 1
    run_txn(1'b0, 1'b0, 18'h00001, 16'h5555, lat, oe_lo, we_lo, drv, wrong);
    chk("fetch_lat", lat, 3);
    chk("fetch_oe_lo", oe_lo, 1);
    chk("fetch_we_lo", we_lo, 0);
    chk("fetch_drv", drv, 0);
    chk("fetch_wrong_ack", wrong, 0);
    chk("fetch_rdata", 32'(o_ifrd), 32'h0004);
    chk("fetch_mem_rdata", 32'(o_memrd), 32'h0);

    // Single write of BEEF to word 1
    run_txn(1'b1, 1'b1, 18'h00001, 16'hBEEF, lat, oe_lo, we_lo, drv, wrong);
    chk("wr_lat", lat, 3);
    chk("wr_we_lo", we_lo, 1);
    chk("wr_oe_lo", oe_lo, 0);
    chk("wr_drv_cycles", drv, 3);
    chk("wr_wrong_ack", wrong, 0);

    // Read-back on the data port
    run_txn(1'b1, 1'b0, 18'h00001, 16'h5555, lat, oe_lo, we_lo, drv, wrong);
    chk("rb_lat", lat, 3);
    chk("rb_rdata", 32'(o_memrd), 32'hBEEF);
    chk("rb_we_lo", we_lo, 0);
    chk("rb_if_hold", 32'(o_ifrd), 32'h0004);

    // Fetch while mem_we is high must still be a read
    run_txn(1'b0, 1'b1, 18'h00001, 16'h5555, lat, oe_lo, we_lo, drv, wrong);
    chk("fwe_we_lo", we_lo, 0);
    chk("fwe_oe_lo", oe_lo, 1);
    chk("fwe_drv", drv, 0);
    chk("fwe_rdata", 32'(o_ifrd), 32'hBEEF);
    chk("fwe_mem_hold", 32'(o_memrd), 32'hBEEF);
    mem_we = 1'b0;

    // WAIT_CYCLES=3 instance
    repeat (6) @(negedge clk);
    sel3 = 1'b1;
    run_txn(1'b0, 1'b0, 18'h00002, 16'h5555, lat, oe_lo, we_lo, drv, wrong);
    chk("w3_lat", lat, 5);
    chk("w3_oe_lo", oe_lo, 3);
    chk("w3_we_lo", we_lo, 0);
    chk("w3_rdata", 32'(o_ifrd), 32'h1234);
    sel3 = 1'b0;
    repeat (2) @(negedge clk);

    // Tie: each requester drops once acked
    @(negedge clk);
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    if_addr = 18'h00003; mem_addr = 18'h00004;
    n_acks = 0; both_ack = 0;
    ack_cyc[0] = -1; ack_cyc[1] = -1; ack_mem[0] = -1; ack_mem[1] = -1;
    for (int c = 1; c <= 40 && n_acks < 2; c++) begin
      @(negedge clk);
      if (bus1.if_ack && bus1.mem_ack) both_ack++;
      if (bus1.mem_ack || bus1.if_ack) begin
        ack_cyc[n_acks] = c;
        ack_mem[n_acks] = bus1.mem_ack ? 1 : 0;
        if (bus1.mem_ack) mem_req = 1'b0;
        if (bus1.if_ack) if_req = 1'b0;
        n_acks++;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("tie_first_mem", ack_mem[0], 1);
    chk("tie_first_cyc", ack_cyc[0], 3);
    chk("tie_second_if", ack_mem[1], 0);
    chk("tie_second_cyc", ack_cyc[1], 7);
    chk("tie_both_ack", both_ack, 0);
    chk("tie_mem_rdata", 32'(bus1.mem_rdata), 32'hC004);
    chk("tie_if_rdata", 32'(bus1.if_rdata), 32'hC003);
    repeat (2) @(negedge clk);

    // Both requests held continuously
    @(negedge clk);
    if_req = 1'b1; mem_req = 1'b1;
    n_acks = 0; n_mem = 0; n_if = 0; alt_err = 0; both_ack = 0; prev_mem = -1;
`ifdef RAM1_ARB_RR_EN
    for (int c = 1; c <= 80 && n_acks < 8; c++) begin
`else
    for (int c = 1; c <= 40 && n_acks < 3; c++) begin
`endif
      @(negedge clk);
      if (bus1.if_ack && bus1.mem_ack) both_ack++;
      if (bus1.mem_ack || bus1.if_ack) begin
        if (prev_mem == (bus1.mem_ack ? 1 : 0)) alt_err++;
        prev_mem = bus1.mem_ack ? 1 : 0;
        if (bus1.mem_ack) n_mem++; else n_if++;
        n_acks++;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("hold_both_ack", both_ack, 0);
`ifdef RAM1_ARB_RR_EN
    chk("rr_mem_count", n_mem, 4);
    chk("rr_if_count", n_if, 4);
    chk("rr_alternation", alt_err, 0);
`else
    chk("fixed_mem_count", n_mem, 3);
    chk("fixed_if_count", n_if, 0);
`endif
    repeat (4) @(negedge clk);

    // Reset during the ACCESS cycle of a write to word 0x10
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00010; mem_wdata = 16'hA5A5;
    @(negedge clk);
    mem_req = 1'b0;
    chk("mrst_setup_drv", 32'(d1), 32'hA5A5);
    @(negedge clk);
    chk("mrst_access_we", 32'(we1), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("mrst_we", 32'(we1), 32'd1);
    chk("mrst_en", 32'(en1), 32'd1);
    chk("mrst_oe", 32'(oe1), 32'd1);
    chk("mrst_data_z", 32'(d1), 32'hFFFF);
    chk("mrst_busy", 32'(busy1), 32'd0);
    chk("mrst_rdata", 32'(bus1.mem_rdata), 32'd0);
    n_acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus1.mem_ack || bus1.if_ack) n_acks++;
    end
    mem_we = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus1.mem_ack || bus1.if_ack) n_acks++;
    end
    chk("mrst_no_ack", n_acks, 0);
    run_txn(1'b1, 1'b0, 18'h00010, 16'h5555, lat, oe_lo, we_lo, drv, wrong);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", 32'(o_memrd), 32'hC010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
